adc_scan_scheduler: RTL

ADC_SCAN_SCHEDULER -- requirements
Module: adc_scan_scheduler

---
 rtl/adc_scan_scheduler_pkg.sv | 24 ++
 rtl/adc_scan_scheduler_if.sv | 28 ++
 rtl/adc_scan_scheduler_sample_tick_gen.sv | 38 +++
 rtl/adc_scan_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_scan_scheduler_pkg.sv
// Shared definitions for the ADC scan scheduler: FSM state encoding and
// the fields of the command word sent to every ADC SPI master.
package adc_scan_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_FIN  = 3'd3,
    S_WRITE     = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [3:0] CMD_PREFIX       = 4'b0001;
  localparam logic       CMD_SINGLE_ENDED = 1'b1;
  localparam logic [1:0] CMD_PAD          = 2'b00;
  localparam logic [6:0] CMD_TRAILER      = 7'b1000000;

  function automatic logic [15:0] make_cmd(input logic [1:0] chan);
    return {CMD_PREFIX, CMD_SINGLE_ENDED, CMD_PAD, chan, CMD_TRAILER};
  endfunction

endpackage

// File: rtl/adc_scan_scheduler_if.sv
// Bus between the scan scheduler (master) and the ADC SPI masters plus the
// shared result FIFO (slave side).
interface adc_scan_scheduler_if #(
  parameter int NUM_ADC = 5
);
  // adc_ena is a one-cycle one-hot request; the addressed ADC answers with a
  // one-cycle adc_fin pulse while its result is valid on adc_data. fifo_wr is
  // a one-cycle write strobe qualified by fifo_din; it is only raised when
  // fifo_full was low, there is no backpressure stall.
  logic [NUM_ADC-1:0]    adc_ena;
  logic [15:0]           adc_cmd;
  logic [NUM_ADC-1:0]    adc_fin;
  logic [16*NUM_ADC-1:0] adc_data;
  logic                  fifo_full;
  logic                  fifo_wr;
  logic [15:0]           fifo_din;

  modport master (
    output adc_ena, adc_cmd, fifo_wr, fifo_din,
    input  adc_fin, adc_data, fifo_full
  );

  modport slave (
    input  adc_ena, adc_cmd, fifo_wr, fifo_din,
    output adc_fin, adc_data, fifo_full
  );

endinterface

// File: rtl/adc_scan_scheduler_sample_tick_gen.sv
// Scan tick generator: counts 0..SAMPLE_DIV-1 and flags the wrap cycle.
// Held at zero (and silent) while clr is high.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 256
) (
  input  logic SYS_CLK,
  input  logic RESETbar,
  input  logic clr,
  output logic tick
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge SYS_CLK or negedge RESETbar) begin
    if (!RESETbar) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/adc_scan_scheduler.sv
// Sequences NUM_ADC SPI ADC masters once per scan tick and pushes tagged
// results into a shared FIFO. Optional FIN watchdog: ADC_SCHED_TIMEOUT_EN.
module adc_scan_scheduler
  import adc_scan_scheduler_pkg::*;
#(
  parameter int NUM_ADC     = 5,
  parameter int SAMPLE_DIV  = 256,
  parameter int FRAME_LEN   = 2048,
  parameter int FIN_TIMEOUT = 64
) (
  input  logic                        SYS_CLK,
  input  logic                        RESETbar,
  input  logic                        start,
  input  logic                        abort,
  input  logic [1:0]                  chan_sel,
  adc_scan_scheduler_if.master        bus,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun,
  output logic                        dropped,
  output logic                        timeout_err,
  output state_t                      state_o
);

  localparam int IW = (NUM_ADC > 1) ? $clog2(NUM_ADC) : 1;
  localparam int SW = $clog2(FRAME_LEN + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ADC - 1);
  localparam logic [SW-1:0] FRAME_END = SW'(FRAME_LEN);

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [SW-1:0]        scan_q, scan_d;
  logic [1:0]           chan_q, chan_d;
  logic [12:0]          data_q, data_d;
  logic [NUM_ADC-1:0]   ena_q, ena_d;
  logic [15:0]          cmd_q, cmd_d;
  logic                 wr_q, wr_d;
  logic [15:0]          din_q, din_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;
  logic                 dropped_q, dropped_d;
  logic                 tick;
  logic                 fin_hit;

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int WDW = (FIN_TIMEOUT > 1) ? $clog2(FIN_TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(FIN_TIMEOUT - 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           tout_q, tout_d;
`endif

  // The tick counter only runs inside a frame, so the first tick lands
  // SAMPLE_DIV cycles after the start edge.
  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .SYS_CLK (SYS_CLK),
    .RESETbar(RESETbar),
    .clr     (state_q == S_IDLE),
    .tick    (tick)
  );

  assign fin_hit = bus.adc_fin[idx_q];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    scan_d    = scan_q;
    chan_d    = chan_q;
    data_d    = data_q;
    din_d     = din_q;
    wr_d      = 1'b0;
    overrun_d = overrun_q;
    dropped_d = dropped_q;
`ifdef ADC_SCHED_TIMEOUT_EN
    wd_d      = wd_q;
    tout_d    = tout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WAIT_TICK;
          chan_d    = chan_sel;
          idx_d     = '0;
          scan_d    = '0;
          overrun_d = 1'b0;
          dropped_d = 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
          tout_d    = 1'b0;
`endif
        end
      end
      S_WAIT_TICK: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (tick) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = abort ? S_DONE : S_WAIT_FIN;
`ifdef ADC_SCHED_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_WAIT_FIN: begin
        // abort is deliberately ignored here so a sample is never split.
        if (fin_hit) begin
          data_d  = bus.adc_data[16*idx_q+3 +: 13];
          state_d = S_WRITE;
        end
`ifdef ADC_SCHED_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          tout_d  = 1'b1;
          state_d = S_NEXT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_WRITE: begin
        if (!bus.fifo_full) begin
          wr_d  = 1'b1;
          din_d = {3'(idx_q), data_q};
        end else begin
          dropped_d = 1'b1;
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_ISSUE;
        end else begin
          idx_d   = '0;
          scan_d  = scan_q + 1'b1;
          state_d = (scan_d == FRAME_END) ? S_DONE : S_WAIT_TICK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (tick && (state_q != S_IDLE) && (state_q != S_WAIT_TICK)) begin
      overrun_d = 1'b1;
    end

    // Outputs are registered from the next state so they line up with it.
    ena_d = '0;
    if (state_d == S_ISSUE) begin
      ena_d[idx_d] = 1'b1;
    end
    cmd_d  = make_cmd(chan_d);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge SYS_CLK or negedge RESETbar) begin
    if (!RESETbar) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      scan_q    <= '0;
      chan_q    <= 2'd0;
      data_q    <= '0;
      ena_q     <= '0;
      cmd_q     <= make_cmd(2'd0);
      wr_q      <= 1'b0;
      din_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      dropped_q <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
      wd_q      <= '0;
      tout_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      scan_q    <= scan_d;
      chan_q    <= chan_d;
      data_q    <= data_d;
      ena_q     <= ena_d;
      cmd_q     <= cmd_d;
      wr_q      <= wr_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      dropped_q <= dropped_d;
`ifdef ADC_SCHED_TIMEOUT_EN
      wd_q      <= wd_d;
      tout_q    <= tout_d;
`endif
    end
  end

  assign bus.adc_ena  = ena_q;
  assign bus.adc_cmd  = cmd_q;
  assign bus.fifo_wr  = wr_q;
  assign bus.fifo_din = din_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overrun      = overrun_q;
  assign dropped      = dropped_q;
  assign state_o      = state_q;
`ifdef ADC_SCHED_TIMEOUT_EN
  assign timeout_err  = tout_q;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule
